// File: rtl/instruction_fetch_unit.sv
// Fetch FSM REQ->WAIT->FULL, one outstanding imem request; 3 cycles/instr at zero wait.
// Holds instruction while inst_ready low; no new request until decode takes it.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt,
    output logic        halted,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_FULL = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] fetch_count_q, fetch_count_d;
    logic        discard_q, discard_d;
    logic        halt_pending_q, halt_pending_d;
    logic [31:0] redirect_tgt;

    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_REQ;
            pc_q           <= RESET_PC;
            inst_q         <= 32'd0;
            inst_pc_q      <= 32'd0;
            fetch_count_q  <= 32'd0;
            discard_q      <= 1'b0;
            halt_pending_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inst_q         <= inst_d;
            inst_pc_q      <= inst_pc_d;
            fetch_count_q  <= fetch_count_d;
            discard_q      <= discard_d;
            halt_pending_q <= halt_pending_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        inst_pc_d      = inst_pc_q;
        fetch_count_d  = fetch_count_q;
        discard_d      = discard_q;
        halt_pending_d = halt_pending_q;

        case (state_q)
            S_REQ: begin
                if (halt) begin
                    if (imem_req_ready) begin
                        state_d        = S_WAIT;
                        halt_pending_d = 1'b1;
                    end else begin
                        state_d = S_HALT;
                    end
                end else begin
                    if (redirect_valid) begin
                        pc_d = redirect_tgt;
                    end
                    if (imem_req_ready) begin
                        state_d = S_WAIT;
                        if (redirect_valid) begin
                            discard_d = 1'b1;
                        end
                    end
                end
            end
            S_WAIT: begin
                // Once halting is decided, redirects can no longer revive fetching.
                if (halt || halt_pending_q) begin
                    halt_pending_d = 1'b1;
                    if (imem_resp_valid) begin
                        discard_d = 1'b0;
                        state_d   = S_HALT;
                    end
                end else if (redirect_valid) begin
                    pc_d = redirect_tgt;
                    if (imem_resp_valid) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        discard_d = 1'b1;
                    end
                end else if (imem_resp_valid) begin
                    if (discard_q) begin
                        discard_d = 1'b0;
                        state_d   = S_REQ;
                    end else begin
                        inst_d    = imem_resp_data;
                        inst_pc_d = pc_q;
                        pc_d      = pc_q + 32'd4;
                        state_d   = S_FULL;
                    end
                end
            end
            S_FULL: begin
                if (inst_ready) begin
                    fetch_count_d = fetch_count_q + 32'd1;
                end
                if (halt) begin
                    state_d = S_HALT;
                end else if (redirect_valid) begin
                    pc_d    = redirect_tgt;
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    state_d = S_REQ;
                end
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
    end

    assign imem_req_valid = !reset && (state_q == S_REQ);
    assign inst_valid     = !reset && (state_q == S_FULL);
    assign halted         = !reset && (state_q == S_HALT);
    assign imem_addr      = pc_q;
    assign inst           = inst_q;
    assign inst_pc        = inst_pc_q;
    assign fetch_count    = fetch_count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Random bench: memory model, expected program-order stream in a queue, monitor on negedge.
module tb_instruction_fetch_unit;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_addr;
    logic        imem_resp_valid = 1'b0;
    logic [31:0] imem_resp_data = 32'd0;
    logic        inst_valid;
    logic        inst_ready = 1'b0;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        halt = 1'b0;
    logic        halted;
    logic [31:0] fetch_count;

    instruction_fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_addr      (imem_addr),
        .imem_resp_valid(imem_resp_valid),
        .imem_resp_data (imem_resp_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Expected program-order addresses of the next instructions to be handed to decode.
    logic [31:0] exp_q[$];
    logic [31:0] tail;
    bit          halting = 0;
    int          halt_age = 0;
    bit          halted_seen = 0;

    logic        s_req_valid = 1'b0;
    logic [31:0] s_addr = 32'd0;
    int          exp_cnt = 0;
    bit          after_reset = 0;
    bit          prev_hold = 0;
    logic [31:0] prev_inst, prev_pc;
    int          idle = 0;

    bit          outstanding = 0;
    logic [31:0] out_addr;
    int          lat = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
        end
    endtask

    task automatic topup();
        while (exp_q.size() < 16) begin
            tail = tail + 32'd4;
            exp_q.push_back(tail);
        end
    endtask

    task automatic restart_stream(input logic [31:0] start);
        exp_q.delete();
        tail = start;
        exp_q.push_back(start);
        topup();
    endtask

    task automatic mon_step();
        logic [31:0] e;
        s_req_valid = imem_req_valid;
        s_addr      = imem_addr;
        if (reset) begin
            check("reset_outputs", {29'd0, imem_req_valid, inst_valid, halted}, 32'd0);
            exp_cnt     = 0;
            after_reset = 1;
            prev_hold   = 0;
            idle        = 0;
            return;
        end
        if (after_reset) begin
            check("reset_addr", imem_addr, RST_PC);
            check("reset_inst", inst, 32'd0);
            check("reset_inst_pc", inst_pc, 32'd0);
            after_reset = 0;
        end
        check("fetch_count", fetch_count, exp_cnt);
        if (prev_hold) begin
            check("stall_valid", {30'd0, inst_valid, imem_req_valid}, 32'd2);
            check("stall_inst", inst, prev_inst);
            check("stall_inst_pc", inst_pc, prev_pc);
        end
        if (inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_handshake", inst_pc, 32'hDEAD_DEAD);
            end else begin
                e = exp_q.pop_front();
                check("inst_pc", inst_pc, e);
                check("inst_data", inst, mem_word(e));
            end
            exp_cnt++;
            idle = 0;
        end else if (!halting) begin
            idle++;
        end
        prev_hold = inst_valid && !inst_ready && !redirect_valid && !halt;
        prev_inst = inst;
        prev_pc   = inst_pc;
        if (halting) begin
            halt_age++;
            check("no_req_when_halting", {31'd0, imem_req_valid}, 32'd0);
            if (halted_seen) begin
                check("halted_sticky", {31'd0, halted}, 32'd1);
            end else if (halted) begin
                halted_seen = 1;
            end else if (halt_age > 12) begin
                check("halt_reached", {31'd0, halted}, 32'd1);
                halted_seen = 1;
            end
        end else begin
            check("halted_low", {31'd0, halted}, 32'd0);
            check("fetch_progress", {31'd0, idle < 150}, 32'd1);
            if (idle >= 150) idle = 0;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            mon_step();
        end
    end

    task automatic step(input bit rst, input bit hlt);
        @(posedge clk);
        #1;
        if (reset) begin
            outstanding = 0;
            halting     = 0;
            restart_stream(RST_PC);
        end else begin
            if (imem_resp_valid) outstanding = 0;
            if (s_req_valid && imem_req_ready) begin
                outstanding = 1;
                out_addr    = s_addr;
                lat         = $urandom_range(0, 3);
            end
            if (halt && !halting) begin
                halting     = 1;
                halt_age    = 0;
                halted_seen = 0;
                exp_q.delete();
            end else if (redirect_valid && !halting) begin
                restart_stream({redirect_pc[31:2], 2'b00});
            end
            if (!halting) topup();
        end
        reset           = rst;
        imem_resp_valid = 1'b0;
        imem_resp_data  = $urandom;
        if (!rst && outstanding) begin
            if (lat == 0) begin
                imem_resp_valid = 1'b1;
                imem_resp_data  = mem_word(out_addr);
            end else begin
                lat--;
            end
        end
        imem_req_ready = ($urandom_range(0, 9) < 7);
        inst_ready     = ($urandom_range(0, 9) < 7);
        redirect_valid = !rst && ($urandom_range(0, 19) == 0);
        case ($urandom_range(0, 3))
            0:       redirect_pc = 32'h0000_0103;
            1:       redirect_pc = 32'hFFFF_FFFE;
            2:       redirect_pc = $urandom;
            default: redirect_pc = $urandom & 32'h0000_0FFF;
        endcase
        halt = !rst && hlt;
    endtask

    initial begin
        int halt_at;
        restart_stream(RST_PC);
        for (int ep = 0; ep < 6; ep++) begin
            step(1'b1, 1'b0);
            step(1'b1, 1'b0);
            halt_at = (ep == 0) ? -1 : int'($urandom_range(30, 250));
            for (int c = 0; c < 300; c++) begin
                step(1'b0, c == halt_at);
            end
        end
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        @(negedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
